// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : segment codes, capture FSM states and decode result type
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package seg7_pkg;

   // Segment patterns, active high, bit order gfedcba
   localparam logic [6:0] SEG7_0     = 7'h3f;
   localparam logic [6:0] SEG7_1     = 7'h06;
   localparam logic [6:0] SEG7_2     = 7'h5b;
   localparam logic [6:0] SEG7_3     = 7'h4f;
   localparam logic [6:0] SEG7_4     = 7'h66;
   localparam logic [6:0] SEG7_5     = 7'h6d;
   localparam logic [6:0] SEG7_6     = 7'h7d;
   localparam logic [6:0] SEG7_7     = 7'h07;
   localparam logic [6:0] SEG7_8     = 7'h7f;
   localparam logic [6:0] SEG7_9     = 7'h6f;
   localparam logic [6:0] SEG7_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } seg7_cap_state_t;

   typedef struct packed {
      logic [3:0] bcd;
      logic       legal;
      logic       blank;
   } seg7_dec_t;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : combinational segment pattern to BCD decoder
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] num,
   output seg7_dec_t  dec
);

   always_comb begin
      dec       = '0;
      dec.legal = 1'b1;
      case (num)
         SEG7_0:     dec.bcd = 4'd0;
         SEG7_1:     dec.bcd = 4'd1;
         SEG7_2:     dec.bcd = 4'd2;
         SEG7_3:     dec.bcd = 4'd3;
         SEG7_4:     dec.bcd = 4'd4;
         SEG7_5:     dec.bcd = 4'd5;
         SEG7_6:     dec.bcd = 4'd6;
         SEG7_7:     dec.bcd = 4'd7;
         SEG7_8:     dec.bcd = 4'd8;
         SEG7_9:     dec.bcd = 4'd9;
         SEG7_BLANK: begin
            dec.legal = 1'b0;
            dec.blank = 1'b1;
         end
         default:    dec.legal = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_capture.sv
// ============================================================================
// seg7_scan_capture : samples a multiplexed 7-segment bus and captures BCD
// Optional stale timeout enabled by defining SEG7_STALE_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_DIGITS-1:0]         ds,
   input  logic [6:0]                    num,
   output logic [4*NUM_DIGITS-1:0]       digits,
   output logic [NUM_DIGITS-1:0]         digit_valid,
   output logic                          upd,
   output logic [$clog2(NUM_DIGITS)-1:0] upd_idx,
   output logic                          code_err,
   output logic                          stale
);

   localparam int         IDX_W      = $clog2(NUM_DIGITS);
   localparam int         SMP_W      = NUM_DIGITS + 7;
   localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYC);

   if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || (NUM_DIGITS & (NUM_DIGITS - 1)) != 0 ||
       STABLE_CYC < 2 || STABLE_CYC > 15 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("seg7_scan_capture: illegal parameter set");
   end

   logic [NUM_DIGITS-1:0]   ds_s1_q, ds_s_q;
   logic [6:0]              num_s1_q, num_s_q;
   logic [SMP_W-1:0]        sample, prev_sample_q;
   seg7_cap_state_t         state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic                    upd_q, upd_d;
   logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
   logic                    code_err_q, code_err_d;
   logic                    sel_ok;
   logic [IDX_W-1:0]        sel_idx;
   logic                    capture;
   seg7_dec_t               dec;

`ifdef SEG7_STALE_TIMEOUT_EN
   localparam int               TMO_W   = $clog2(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             stale_q, stale_d;
`endif

   assign sample = {ds_s_q, num_s_q};

   seg7_decode u_decode (
      .num (num_s_q),
      .dec (dec)
   );

   // Exactly one select line low means a single digit is being driven
   always_comb begin
      sel_ok  = $onehot(~ds_s_q);
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!ds_s_q[i]) sel_idx = i[IDX_W-1:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      digits_d   = digits_q;
      valid_d    = valid_q;
      upd_d      = 1'b0;
      upd_idx_d  = upd_idx_q;
      code_err_d = 1'b0;
      capture    = 1'b0;

      if (!sel_ok) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_TRACK;
               cnt_d   = 4'd1;
            end
            ST_TRACK: begin
               if (sample != prev_sample_q) begin
                  cnt_d = 4'd1;
               end else if (cnt_q + 4'd1 == STABLE_LIM) begin
                  capture = 1'b1;
                  state_d = ST_LOCKED;
                  cnt_d   = STABLE_LIM;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            ST_LOCKED: begin
               if (sample != prev_sample_q) begin
                  state_d = ST_TRACK;
                  cnt_d   = 4'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end

      if (capture) begin
         if (dec.legal) begin
            digits_d[{sel_idx, 2'b00} +: 4] = dec.bcd;
            valid_d[sel_idx]                = 1'b1;
            upd_d                           = 1'b1;
            upd_idx_d                       = sel_idx;
         end else if (dec.blank) begin
            valid_d[sel_idx] = 1'b0;
            upd_d            = 1'b1;
            upd_idx_d        = sel_idx;
         end else begin
            code_err_d = 1'b1;
         end
      end

`ifdef SEG7_STALE_TIMEOUT_EN
      tmo_d   = tmo_q;
      stale_d = stale_q;
      // A fresh capture always wins over an expiring timeout in the same cycle
      if (upd_d) begin
         tmo_d   = '0;
         stale_d = 1'b0;
      end else if (tmo_q == TMO_LIM) begin
         stale_d = 1'b1;
         valid_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ds_s1_q       <= '1;
         ds_s_q        <= '1;
         num_s1_q      <= '0;
         num_s_q       <= '0;
         prev_sample_q <= {{NUM_DIGITS{1'b1}}, 7'h00};
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         digits_q      <= '0;
         valid_q       <= '0;
         upd_q         <= 1'b0;
         upd_idx_q     <= '0;
         code_err_q    <= 1'b0;
`ifdef SEG7_STALE_TIMEOUT_EN
         tmo_q         <= '0;
         stale_q       <= 1'b0;
`endif
      end else begin
         ds_s1_q       <= ds;
         ds_s_q        <= ds_s1_q;
         num_s1_q      <= num;
         num_s_q       <= num_s1_q;
         prev_sample_q <= sample;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         digits_q      <= digits_d;
         valid_q       <= valid_d;
         upd_q         <= upd_d;
         upd_idx_q     <= upd_idx_d;
         code_err_q    <= code_err_d;
`ifdef SEG7_STALE_TIMEOUT_EN
         tmo_q         <= tmo_d;
         stale_q       <= stale_d;
`endif
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign upd         = upd_q;
   assign upd_idx     = upd_idx_q;
   assign code_err    = code_err_q;
`ifdef SEG7_STALE_TIMEOUT_EN
   assign stale       = stale_q;
`else
   assign stale       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
// ============================================================================
// tb_seg7_scan_capture : directed bench with an event scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_scan_capture;

   logic        clk;
   logic        rst_n;
   logic [7:0]  ds;
   logic [6:0]  num;
   logic [31:0] digits;
   logic [7:0]  digit_valid;
   logic        upd;
   logic [2:0]  upd_idx;
   logic        code_err;
   logic        stale;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic        is_err;
      logic [2:0]  idx;
      logic [31:0] digits;
      logic [7:0]  valid;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_digits;
   logic [7:0]  m_valid;

   seg7_scan_capture #(
      .NUM_DIGITS  (8),
      .STABLE_CYC  (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ds          (ds),
      .num         (num),
      .digits      (digits),
      .digit_valid (digit_valid),
      .upd         (upd),
      .upd_idx     (upd_idx),
      .code_err    (code_err),
      .stale       (stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_upd(input logic [2:0] idx, input logic [3:0] bcd);
      m_digits[{idx, 2'b00} +: 4] = bcd;
      m_valid[idx]                = 1'b1;
      q.push_back('{1'b0, idx, m_digits, m_valid});
   endtask

   task automatic push_blank(input logic [2:0] idx);
      m_valid[idx] = 1'b0;
      q.push_back('{1'b0, idx, m_digits, m_valid});
   endtask

   task automatic push_err();
      q.push_back('{1'b1, 3'd0, m_digits, m_valid});
   endtask

   // Every upd/code_err pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (upd === 1'b1 || code_err === 1'b1)) begin
         exp_t e;
         check("upd_err_exclusive", {63'd0, upd & code_err}, 64'd0);
         n_cmp++;
         assert (q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_event: observed upd=%0b code_err=%0b idx=%0d, expected no event",
                   upd, code_err, upd_idx);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            check("evt_kind_err", {63'd0, code_err}, {63'd0, e.is_err});
            if (!e.is_err) check("evt_idx", {61'd0, upd_idx}, {61'd0, e.idx});
            check("evt_digits", {32'd0, digits}, {32'd0, e.digits});
            check("evt_valid", {56'd0, digit_valid}, {56'd0, e.valid});
         end
      end
   end

   initial begin
      m_digits = '0;
      m_valid  = '0;
      rst_n    = 1'b0;
      ds       = 8'h3c;
      num      = 7'h5b;

      // Reset state
      tick(3);
      check("rst_digits", {32'd0, digits}, 64'd0);
      check("rst_valid", {56'd0, digit_valid}, 64'd0);
      check("rst_upd", {63'd0, upd}, 64'd0);
      check("rst_upd_idx", {61'd0, upd_idx}, 64'd0);
      check("rst_code_err", {63'd0, code_err}, 64'd0);
      check("rst_stale", {63'd0, stale}, 64'd0);

      rst_n = 1'b1;
      ds    = 8'hff;
      num   = 7'h00;
      tick(20);
      check("idle_no_events", q.size(), 64'd0);

      // Single digit: capture visible right after the fifth edge
      ds  = 8'b1110_1111;
      num = 7'h5b;
      push_upd(3'd4, 4'd2);
      tick(5);
      check("single_upd_early", {63'd0, upd}, 64'd0);
      tick(1);
      check("single_upd_edge5", {63'd0, upd}, 64'd1);
      check("single_upd_idx", {61'd0, upd_idx}, 64'd4);
      check("single_digits", {32'd0, digits}, 64'h0002_0000);
      check("single_valid", {56'd0, digit_valid}, 64'h10);
      tick(4);
      check("single_one_upd", q.size(), 64'd0);

      // Scanning pair
      for (int r = 0; r < 2; r++) begin
         ds  = 8'b1110_1111;
         num = 7'h06;
         push_upd(3'd4, 4'd1);
         tick(8);
         check("scan_phase_a", q.size(), 64'd0);
         ds  = 8'b1101_1111;
         num = 7'h7f;
         push_upd(3'd5, 4'd8);
         tick(8);
         check("scan_phase_b", q.size(), 64'd0);
      end
      check("scan_digits", {32'd0, digits}, 64'h0081_0000);
      check("scan_valid", {56'd0, digit_valid}, 64'h30);

      // Short-lived pattern, then multi-select
      ds  = 8'b1110_1111;
      num = 7'h3f;
      tick(3);
      num = 7'h7f;
      tick(3);
      ds  = 8'hff;
      num = 7'h00;
      tick(4);
      check("glitch_no_upd", q.size(), 64'd0);
      ds  = 8'b1100_1111;
      num = 7'h3f;
      tick(20);
`ifdef SEG7_STALE_TIMEOUT_EN
      m_valid = '0;
`endif
      check("multi_no_upd", q.size(), 64'd0);
      check("multi_digits", {32'd0, digits}, {32'd0, m_digits});
      check("multi_valid", {56'd0, digit_valid}, {56'd0, m_valid});

      // Illegal code then blank on digit 4
      ds  = 8'b1110_1111;
      num = 7'h7e;
      push_err();
      tick(10);
      check("illegal_one_err", q.size(), 64'd0);
      num = 7'h00;
      push_blank(3'd4);
      tick(10);
      check("blank_one_upd", q.size(), 64'd0);
      check("blank_digits", {32'd0, digits}, 64'h0081_0000);
      check("blank_valid", {56'd0, digit_valid}, {56'd0, m_valid});

      // Reset in the middle of a capture window
      ds  = 8'b1111_1110;
      num = 7'h06;
      tick(3);
      rst_n = 1'b0;
      #1;
      check("midrst_digits", {32'd0, digits}, 64'd0);
      check("midrst_valid", {56'd0, digit_valid}, 64'd0);
      check("midrst_upd", {63'd0, upd}, 64'd0);
      check("midrst_code_err", {63'd0, code_err}, 64'd0);
      m_digits = '0;
      m_valid  = '0;
      tick(2);
      rst_n = 1'b1;
      push_upd(3'd0, 4'd1);
      tick(10);
      check("midrst_recapture", q.size(), 64'd0);

      // Idle period after a capture: stale timeout if built in
      num = 7'h4f;
      push_upd(3'd0, 4'd3);
      tick(5);
      check("tmo_cap_early", {63'd0, upd}, 64'd0);
      tick(1);
      check("tmo_cap_upd", {63'd0, upd}, 64'd1);
      ds  = 8'hff;
      num = 7'h00;
      tick(15);
      check("tmo_before_stale", {63'd0, stale}, 64'd0);
      check("tmo_before_valid", {56'd0, digit_valid}, 64'h01);
      tick(1);
`ifdef SEG7_STALE_TIMEOUT_EN
      m_valid = '0;
      check("tmo_stale_set", {63'd0, stale}, 64'd1);
`else
      check("tmo_stale_tied", {63'd0, stale}, 64'd0);
`endif
      check("tmo_valid", {56'd0, digit_valid}, {56'd0, m_valid});

      ds  = 8'b1111_1101;
      num = 7'h66;
      push_upd(3'd1, 4'd4);
      tick(10);
      check("tmo_recap_events", q.size(), 64'd0);
      check("tmo_recap_stale", {63'd0, stale}, 64'd0);
      check("tmo_recap_digits", {32'd0, digits}, 64'h0000_0043);
      check("tmo_recap_valid", {56'd0, digit_valid}, {56'd0, m_valid});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Samples the active-low digit-select bus and the 7-bit segment bus, and decodes stable patterns back to BCD.
- Holds one BCD nibble plus a valid flag per digit position.
- Used as an on-chip loopback checker and self-test monitor for the display path.

Parameters:
- NUM_DIGITS, 8, number of digit-select lines and digit positions; must be a power of two, at most 16.
- STABLE_CYC, 4, consecutive identical synchronized samples required before capture; range 2..15.
- TIMEOUT_CYC, 1024, stale timeout in clk cycles; used only with SEG7_STALE_TIMEOUT_EN.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ds  in  NUM_DIGITS  digit select, active low; bit i low selects digit i.
- num  in  7  segment pattern, active high, bit order gfedcba.
- digits  out  4*NUM_DIGITS  captured BCD; digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i holds a decoded value (not blank, not never-seen).
- upd  out  1  one-cycle pulse on each capture, valid or blank.
- upd_idx  out  $clog2(NUM_DIGITS)  index of the digit captured with upd; holds its last value otherwise.
- code_err  out  1  one-cycle pulse when a stable pattern is not a legal code.
- stale  out  1  level; only meaningful with SEG7_STALE_TIMEOUT_EN, tied 0 otherwise.

Behaviour:
- Reset (async assert, sync release):
  - digits=0, digit_valid=0, upd=0, upd_idx=0, code_err=0, stale=0.
  - Both sync stages load ds=all-ones and num=0; stability counter=0; state IDLE.
- Input path:
  - ds and num pass through a 2-flop synchronizer each.
  - The sample is {ds_s, num_s}; prev_sample is the sample registered one cycle earlier.
- States: IDLE, TRACK, LOCKED.
- IDLE → TRACK when ds_s has exactly one zero bit. The counter loads 1.
- IDLE hold: ds_s all-ones or more than one zero bit. The counter stays 0.
- In any state, if ds_s becomes non-one-hot-low: go to IDLE, counter=0, no capture.
- In TRACK:
  - sample==prev_sample: counter increments.
  - sample!=prev_sample and still one-hot: counter reloads 1 and the state stays TRACK.
  - When the counter would reach STABLE_CYC: perform the capture and go to LOCKED.
- In LOCKED: no further capture. Any sample change goes to TRACK with counter=1 (or to IDLE per the rule above).
- Capture latency: for an input change sampled at edge 0 and held, the outputs update at edge STABLE_CYC+1. Default: edge 5.
- Capture decode:
  - 3f→0, 06→1, 5b→2, 4f→3, 66→4, 6d→5, 7d→6, 07→7, 7f→8, 6f→9.
  - Legal digit: write digits[idx], set digit_valid[idx]=1, pulse upd, upd_idx=idx.
  - 7'h00 (blank): clear digit_valid[idx], leave digits[idx] unchanged, pulse upd, upd_idx=idx.
  - Any other pattern: pulse code_err only; no other output changes.
- Upd and code_err never assert in the same cycle, and each asserts at most once per LOCKED entry.
- Reset mid-capture: outputs clear immediately and the counter restarts from IDLE.

Optional Feature:
- Macro: SEG7_STALE_TIMEOUT_EN.
- Defined:
  - A free-running counter clears on every upd.
  - On reaching TIMEOUT_CYC-1 without an upd: clear all digit_valid, set stale=1, and saturate the counter.
  - The next upd clears stale.
- Undefined: no counter, stale tied 0, and TIMEOUT_CYC is unused.

Decomposition:
- Package seg7_pkg holds:
  - Segment constants SEG7_0..SEG7_9 and SEG7_BLANK.
  - The state enum typedef seg7_cap_state_t.
  - The decode result struct {bcd[3:0], legal, blank}.
- Sub-module seg7_decode: purely combinational num→bcd/legal/blank. The same module is shared with the transmit-side driver's checker.

Test Plan:
- Reset: assert rst_n=0 with arbitrary ds/num → all outputs 0; release; hold ds=8'hFF for 20 cycles → no upd, no code_err.
- Single digit: ds=8'b1110_1111, num=7'h5b held 10 cycles → exactly one upd at edge 5, upd_idx=4, digits[19:16]=4'd2, digit_valid=8'h10.
- Scanning pair: alternate every 8 cycles between ds=8'b1110_1111/num=7'h06 and ds=8'b1101_1111/num=7'h7f → digits[19:16]=1, digits[23:20]=8, digit_valid=8'h30, one upd per phase.
- Glitch and multi-select:
  - num=7'h3f held 3 cycles, then changed → no upd.
  - ds=8'b1100_1111 held 20 cycles → no upd, digits unchanged.
- Illegal and blank:
  - num=7'h7e stable on digit 4 → one code_err pulse, digits/digit_valid unchanged.
  - Then num=7'h00 stable → upd pulse, digit_valid[4]=0, digits[19:16] unchanged.
- With SEG7_STALE_TIMEOUT_EN and TIMEOUT_CYC=16:
  - Capture digit 0, then hold ds=8'hFF → digit_valid=0 and stale=1 exactly 16 cycles after upd.
  - Next capture → stale=0.
